gray_count_tracker: RTL
=======================

// Module: gray_count_tracker
//
// PURPOSE
// Receiving end of a Gray-coded up/down count bus, as driven by the team's Gray up/down counters.
// Samples an N-bit Gray value, decodes it to binary and classifies each sample against the previous one:
//   - hold
//   - single step up
//   - single step down
//   - illegal jump
// Reports direction, wrap-around and error status, so a count crossing a clock or module boundary can be checked and consumed.
//
// PARAMETERS
// N      4   width of Gray input and binary output
// ERR_W  8   width of saturating error counter
//
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous, active-low reset
// clear      in   1      synchronous clear: state, outputs and err_cnt to reset values
// sample_en  in   1      take gray_in this cycle
// gray_in    in   N      Gray-coded count from the transmitting counter
// bin_out    out  N      decoded binary count, registered
// locked     out  1      1 = reference established, tracking steps
// step       out  1      1-cycle pulse: legal +1/-1 step accepted
// dir        out  1      direction of last accepted step, 1 = up, 0 = down
// wrap       out  1      1-cycle pulse: step crossed 2^N-1 <-> 0
// err        out  1      1-cycle pulse: illegal jump detected
// err_cnt    out  ERR_W  errors since reset/clear, saturates at 2^ERR_W-1
//
// BEHAVIOUR
// - Reset (rst_n=0, async) and clear=1 (sync) give identical state:
//   - bin_out=0, locked=0, step=0, dir=1, wrap=0, err=0, err_cnt=0; FSM in UNSYNC.
// - Priority: rst_n > clear > sample_en. A sample coinciding with clear is discarded.
// - Decode (combinational on the sampled word): b[N-1]=g[N-1]; b[i]=b[i+1]^g[i].
// - delta = b - bin_out, modulo 2^N (N-bit wrap arithmetic).
// - Latency: outputs reflect a sample on the clock edge that takes it (1 cycle).
// - step, wrap and err deassert in any cycle with no qualifying sample.
// - FSM states: UNSYNC, TRACK.
//   - UNSYNC + sample: bin_out<=b, locked<=1, go to TRACK. No step, no err, dir unchanged.
//   - TRACK + sample, delta==0: hold. No pulses.
//   - TRACK + sample, delta==1: bin_out<=b, step=1, dir<=1. wrap=1 if b==0.
//   - TRACK + sample, delta==2^N-1: bin_out<=b, step=1, dir<=0. wrap=1 if b==2^N-1.
//   - TRACK + sample, any other delta: err=1, err_cnt+1 (saturating), bin_out holds, locked<=0, go to UNSYNC.
//     The next sample re-establishes the reference silently.
// - No sample: all registers hold; pulses low.
// - rst_n asserted mid-operation: outputs go to reset values immediately, not on the next edge.
//
// CONFIGURATION
// GRAY_TRACK_SYNC_EN
// - Defined:
//   - gray_in and sample_en pass through a 2-flop synchroniser, reset to 0 by rst_n.
//   - Sample-to-output latency becomes 3 cycles.
//   - For gray_in driven from another clock domain.
// - Undefined: gray_in/sample_en used directly; latency 1 cycle; source must be synchronous to clk.
//
// TESTING (N=4, ERR_W=8 unless stated; latencies per macro setting)
// 1. Release rst_n; sample gray 0000 -> locked=1, bin_out=0, step=0, err=0.
// 2. Up run, gray 0001, 0011, 0010 -> bin_out 1, 2, 3; step pulse on each; dir=1; wrap=0.
// 3. Wrap both ways:
//    - From bin 15 (gray 1000), sample 0000 -> bin_out=0, dir=1, wrap=1.
//    - Then sample 1000 -> bin_out=15, dir=0, wrap=1.
// 4. Illegal jump:
//    - At bin 2, sample gray 0110 (bin 4) -> err=1, err_cnt=1, locked=0, bin_out=2.
//    - Then sample 0111 -> locked=1, bin_out=5, step=0.
// 5. Priority and reset:
//    - clear=1 with sample_en=1, gray 0001 -> bin_out=0, locked=0, err_cnt=0.
//    - rst_n low between edges -> outputs reset before the next edge.
// 6. Saturation: ERR_W=2, force 5 illegal jumps (re-lock between) -> err_cnt sticks at 3; err pulses 5 times.

Source files
------------

// File: rtl/gray_count_tracker.sv
// ---------------------------------------------------------------------------
// gray_count_tracker
//
// Receiving end of a Gray-coded up/down count bus. Each taken sample is
// decoded to binary and compared with the last accepted count. The result
// is one of four outcomes:
//   - hold
//   - a single step up
//   - a single step down
//   - an illegal jump
// An illegal jump drops the lock. The next sample then silently becomes
// the new reference.
//
// Parameters:
//   N      width of the Gray input and the binary output
//   ERR_W  width of the saturating error counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear back to the reset state (wins over sample_en)
//   sample_en  take gray_in this cycle
//   gray_in    Gray-coded count from the transmitting counter
//   bin_out    decoded binary count of the last accepted sample
//   locked     reference established, steps are being tracked
//   step       1-cycle pulse, legal +1/-1 step accepted
//   dir        direction of the last accepted step (1 = up, 0 = down)
//   wrap       1-cycle pulse, step crossed 2^N-1 <-> 0
//   err        1-cycle pulse, illegal jump detected
//   err_cnt    errors since reset/clear, saturating
//
// Configuration macro: GRAY_TRACK_SYNC_EN
//   Defined   : gray_in and sample_en pass through a 2-flop synchroniser,
//               giving a sample-to-output latency of 3 cycles.
//   Undefined : inputs are used directly (latency 1 cycle). The source must
//               be synchronous to clk.
// ---------------------------------------------------------------------------
module gray_count_tracker #(
   parameter int N     = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             sample_en,
   input  logic [N-1:0]     gray_in,
   output logic [N-1:0]     bin_out,
   output logic             locked,
   output logic             step,
   output logic             dir,
   output logic             wrap,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic {UNSYNC, TRACK} state_t;

   state_t         state;
   logic [N-1:0]   gray_s;
   logic           en_s;
   logic [N-1:0]   b_dec;
   logic [N-1:0]   delta;

`ifdef GRAY_TRACK_SYNC_EN
   logic [N-1:0]   gray_meta;
   logic [N-1:0]   gray_sync;
   logic           en_meta;
   logic           en_sync;

   // Two-stage synchroniser for a source in another clock domain.
   // Only rst_n clears it; clear acts on the tracker itself.
   // Bus coherence relies on the source changing one Gray bit at a time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_meta <= '0;
         gray_sync <= '0;
         en_meta   <= 1'b0;
         en_sync   <= 1'b0;
      end else begin
         gray_meta <= gray_in;
         gray_sync <= gray_meta;
         en_meta   <= sample_en;
         en_sync   <= en_meta;
      end
   end

   assign gray_s = gray_sync;
   assign en_s   = en_sync;
`else
   assign gray_s = gray_in;
   assign en_s   = sample_en;
`endif

   // Gray-to-binary decode: binary bit i is the XOR of Gray bits i..N-1.
   // This is the same as b[N-1]=g[N-1], b[i]=b[i+1]^g[i], written without
   // a combinational self-reference.
   always_comb begin
      b_dec = '0;
      for (int i = 0; i < N; i++) begin
         b_dec[i] = ^(gray_s >> i);
      end
   end

   // Modulo-2^N distance from the last accepted count.
   // 1 means up, all-ones means down.
   assign delta = b_dec - bin_out;

   // Tracker FSM with registered outputs. Pulses default low every cycle
   // and are raised only by a qualifying sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= UNSYNC;
         bin_out <= '0;
         locked  <= 1'b0;
         step    <= 1'b0;
         dir     <= 1'b1;
         wrap    <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (clear) begin
         state   <= UNSYNC;
         bin_out <= '0;
         locked  <= 1'b0;
         step    <= 1'b0;
         dir     <= 1'b1;
         wrap    <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
         err  <= 1'b0;
         if (en_s) begin
            case (state)
               UNSYNC: begin
                  bin_out <= b_dec;
                  locked  <= 1'b1;
                  state   <= TRACK;
               end
               TRACK: begin
                  if (delta == '0) begin
                     bin_out <= bin_out;
                  end else if (delta == N'(1)) begin
                     bin_out <= b_dec;
                     step    <= 1'b1;
                     dir     <= 1'b1;
                     wrap    <= (b_dec == '0);
                  end else if (delta == '1) begin
                     bin_out <= b_dec;
                     step    <= 1'b1;
                     dir     <= 1'b0;
                     wrap    <= (b_dec == '1);
                  end else begin
                     err    <= 1'b1;
                     locked <= 1'b0;
                     state  <= UNSYNC;
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                     end
                  end
               end
               default: state <= UNSYNC;
            endcase
         end
      end
   end

endmodule
